// File: rtl/ps2_char_source.sv
// ps2_char_source: receives PS/2 keyboard frames, decodes scan-set-2 make
// codes for A-Z / 0-9 into 6-bit character codes (A=0 .. Z=25, '1'=26 ..
// '9'=34, '0'=35) and offers them one at a time on a valid/ready handshake.
//
// Ports:
//   clk         system clock (100 MHz)
//   clr         asynchronous active-low reset
//   ps2_clk     raw PS/2 clock line (asynchronous)
//   ps2_data    raw PS/2 data line (asynchronous)
//   char_ready  consumer accepts char_code while char_valid is high
//   char_code   decoded character code
//   char_valid  char_code holds an unconsumed code
//   frame_err   one-cycle pulse on a bad or timed-out frame
//   overflow    one-cycle pulse when a decoded code is dropped
module ps2_char_source #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       char_ready,
    output logic [5:0] char_code,
    output logic       char_valid,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic [9:0]             shreg,     shreg_nxt;
    logic [BW-1:0]          bit_cnt,   bit_nxt;
    logic [TW-1:0]          tmo_cnt,   tmo_nxt;
    state_t                 state,     state_nxt;
    logic [5:0]             code_nxt;
    logic                   valid_nxt, err_nxt, ovf_nxt;

    logic        clk_s, data_s, fall;
    logic [10:0] frame;
    logic [7:0]  rx_byte;
    logic        frame_ok, hit, emit;
    logic [5:0]  map_code;

    // Two-or-more flop synchronizers; lines idle high so they reset to 1
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Full frame as seen on the 11th edge: live data bit is the stop bit
    assign frame    = {data_s, shreg};
    assign rx_byte  = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    // Scan set 2 make code -> character code
    always_comb begin
        hit      = 1'b1;
        map_code = 6'd0;
        case (rx_byte)
            8'h1C: map_code = 6'd0;   8'h32: map_code = 6'd1;
            8'h21: map_code = 6'd2;   8'h23: map_code = 6'd3;
            8'h24: map_code = 6'd4;   8'h2B: map_code = 6'd5;
            8'h34: map_code = 6'd6;   8'h33: map_code = 6'd7;
            8'h43: map_code = 6'd8;   8'h3B: map_code = 6'd9;
            8'h42: map_code = 6'd10;  8'h4B: map_code = 6'd11;
            8'h3A: map_code = 6'd12;  8'h31: map_code = 6'd13;
            8'h44: map_code = 6'd14;  8'h4D: map_code = 6'd15;
            8'h15: map_code = 6'd16;  8'h2D: map_code = 6'd17;
            8'h1B: map_code = 6'd18;  8'h2C: map_code = 6'd19;
            8'h3C: map_code = 6'd20;  8'h2A: map_code = 6'd21;
            8'h1D: map_code = 6'd22;  8'h22: map_code = 6'd23;
            8'h35: map_code = 6'd24;  8'h1A: map_code = 6'd25;
            8'h16: map_code = 6'd26;  8'h1E: map_code = 6'd27;
            8'h26: map_code = 6'd28;  8'h25: map_code = 6'd29;
            8'h2E: map_code = 6'd30;  8'h36: map_code = 6'd31;
            8'h3D: map_code = 6'd32;  8'h3E: map_code = 6'd33;
            8'h46: map_code = 6'd34;  8'h45: map_code = 6'd35;
            default: hit = 1'b0;
        endcase
    end

    // Frame receive, timeout, decoder FSM and output handshake next-state
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        tmo_nxt   = tmo_cnt;
        code_nxt  = char_code;
        valid_nxt = char_valid & ~char_ready;
        err_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        emit      = 1'b0;

        if (fall) begin
            tmo_nxt   = '0;
            shreg_nxt = {data_s, shreg[9:1]};
            if (bit_cnt == BW'(10)) begin
                bit_nxt = '0;
                if (frame_ok) begin
                    case (state)
                        IDLE: begin
                            if (rx_byte == 8'hF0)      state_nxt = BRK;
                            else if (rx_byte == 8'hE0) state_nxt = EXT;
                            else                       emit      = hit;
                        end
                        EXT:     state_nxt = (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
                        default: state_nxt = IDLE;
                    endcase
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                bit_nxt = bit_cnt + BW'(1);
            end
        end else if (bit_cnt != '0) begin
            // Mid-frame with no edge: abort once the gap reaches the limit
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_nxt = '0;
                bit_nxt = '0;
                err_nxt = 1'b1;
            end else begin
                tmo_nxt = tmo_cnt + TW'(1);
            end
        end else begin
            tmo_nxt = '0;
        end

        // A held, unaccepted code wins; the new one is dropped
        if (emit) begin
            if (char_valid && !char_ready) begin
                ovf_nxt = 1'b1;
            end else begin
                code_nxt  = map_code;
                valid_nxt = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            clk_prev   <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            state      <= IDLE;
            char_code  <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            clk_prev   <= clk_s;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_nxt;
            tmo_cnt    <= tmo_nxt;
            state      <= state_nxt;
            char_code  <= code_nxt;
            char_valid <= valid_nxt;
            frame_err  <= err_nxt;
            overflow   <= ovf_nxt;
        end
    end

endmodule

// File: doc/ps2_char_source.md
Name: ps2_char_source

Overview:
- Upstream producer for the character display stage; that stage renders 6-bit character codes 0-35 (A-Z, then 1-9, then 0) as 9x9 glyphs.
- This block receives PS/2 keyboard frames and decodes scan-set-2 make codes into that 6-bit code space.
- It presents one decoded key press at a time on a valid/ready handshake; the consumer is the screen text buffer writer.
- It runs on the 100 MHz system clock, the same clock the display stage divides down to its 25 MHz pixel clock.

Parameters:
- TIMEOUT_CYCLES, 100000, number of clk cycles without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on ps2_clk and ps2_data (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz.
- clr  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line; asynchronous.
- ps2_data  input  1  raw PS/2 data line; asynchronous.
- char_ready  input  1  consumer accepts char_code when high in the same cycle as char_valid.
- char_code  output  6  decoded code: A=0 .. Z=25, '1'=26 .. '9'=34, '0'=35.
- char_valid  output  1  char_code holds an unconsumed code.
- frame_err  output  1  one-cycle pulse on a bad or timed-out frame.
- overflow  output  1  one-cycle pulse when a decoded code is dropped.

Behaviour:
Reset (clr low):
- char_code=0, char_valid=0, frame_err=0, overflow=0.
- Bit counter=0, decoder state=IDLE, timeout counter=0.
- Synchronizers load 1.
- Reset takes effect immediately; any partial frame is discarded.

Frame receive:
- Synchronize both lines through SYNC_STAGES flops.
- Detect a falling edge of synchronized ps2_clk (previous=1, current=0).
- On each falling edge, sample synchronized ps2_data into an 11-bit shift register in this order: start, d0..d7 (LSB first), parity, stop.
- The frame completes on the 11th edge.
- Valid frame: start=0, stop=1, and XOR(d0..d7, parity)=1 (odd parity).
- Invalid frame: frame_err pulses high in the cycle after the 11th edge; the byte is discarded and the decoder state is unchanged.
- Timeout: while bit counter is 1..10, count cycles since the last edge. On reaching TIMEOUT_CYCLES, clear the bit counter, pulse frame_err, and discard the byte. The counter clears on every edge.

Decoder FSM (acts on valid bytes only):
- IDLE:
  - 0xF0 -> BREAK.
  - 0xE0 -> EXT.
  - A mapped make code -> emit, stay in IDLE.
  - Anything else -> ignore, stay in IDLE.
- BREAK: any byte -> IDLE, no emit.
- EXT:
  - 0xF0 -> EXT_BREAK.
  - Any other byte -> IDLE, no emit.
- EXT_BREAK: any byte -> IDLE, no emit.

Mapping (scan set 2, hex -> code):
- 1C->0, 32->1, 21->2, 23->3, 24->4, 2B->5, 34->6, 33->7, 43->8
- 3B->9, 42->10, 4B->11, 3A->12, 31->13, 44->14, 4D->15, 15->16
- 2D->17, 1B->18, 2C->19, 3C->20, 2A->21, 1D->22, 22->23, 35->24
- 1A->25, 16->26, 1E->27, 26->28, 25->29, 2E->30, 36->31, 3D->32
- 3E->33, 46->34, 45->35
- All other bytes are unmapped.

Output handshake:
- Emit latency: char_valid rises in the cycle after the 11th falling edge is detected.
- char_code and char_valid stay stable until char_valid && char_ready is seen at a rising clk edge.
- Emit while char_valid=0: load the code and set char_valid.
- Emit while char_valid=1 and char_ready=0: keep the held code, drop the new one, pulse overflow.
- Emit while char_valid=1 and char_ready=1: load the new code; char_valid stays 1.
- Handshake with no emit: char_valid clears next cycle.
- frame_err and overflow never both pulse from the same byte.

Test Plan:
- Reset, then send a valid frame for 0x1C with char_ready=1 -> char_valid pulses for 1 cycle with char_code=0, one cycle after the 11th falling edge; frame_err=0.
- Send 0x45, then 0xF0, 0x45 with char_ready=1 -> exactly one emit, char_code=35; the break sequence produces no output.
- Send 0xE0, 0x1C, then 0x32 -> no emit for 0x1C; one emit with char_code=1.
- Send 0x1C with a wrong parity bit, then separately 0x1C with stop=0 -> frame_err pulses once per frame, char_valid stays 0, FSM stays IDLE (a following 0x1C emits 0).
- Send 4 bits, then idle for TIMEOUT_CYCLES -> frame_err pulses once; a following full 0x2C frame emits char_code=19.
- With char_ready=0, send 0x16 then 0x1E -> char_code=26 held and overflow pulses once; raise char_ready -> char_valid clears next cycle. Also drive clr low mid-frame -> all outputs 0 and the partial frame is discarded.
